// File: rtl/fetch_decode_ctrl_if.sv
// PC / instruction-memory side bundle of the fetch-decode controller.
// master = controller, slave = PC + imem environment.
interface fetch_decode_ctrl_if #(
  parameter int IW = 9,
  parameter int AW = 12
);
  logic [31:0]   pc_in;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic          branch_en;
  logic          zero;
  logic [7:0]    immediate;

  modport master (
    input  pc_in,
    input  imem_rdata,
    output imem_addr,
    output branch_en,
    output zero,
    output immediate
  );

  modport slave (
    output pc_in,
    output imem_rdata,
    input  imem_addr,
    input  branch_en,
    input  zero,
    input  immediate
  );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode controller: decodes imem word, drives PC branch controls,
// holds compare zero flag and run/done/fault state with retire counters.
module fetch_decode_ctrl #(
  parameter int IW    = 9,
  parameter int AW    = 12,
  parameter int DEPTH = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_decode_ctrl_if.master  bus,
  input  logic                 alu_zero,
  output logic [IW-1:0]        instr_out,
  output logic                 instr_valid,
  output logic                 done,
  output logic                 fault,
  output logic [31:0]          instr_count,
  output logic [15:0]          taken_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DONE  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t     state;
  logic       zero_q;
  logic [2:0] op;
  logic       in_range;
  logic       is_br;
  logic       is_cmp;
  logic       is_halt;

  assign op       = bus.imem_rdata[8:6];
  assign in_range = bus.pc_in < DEPTH_W;

  always_comb begin
    is_br   = 1'b0;
    is_cmp  = 1'b0;
    is_halt = 1'b0;
    unique case (1'b1)
      (op == 3'b111): is_br  = 1'b1;
      (op == 3'b101): is_cmp = 1'b1;
      (op == 3'b110): is_halt = (bus.imem_rdata[5:0] == 6'h3F);
      default: ;
    endcase
  end

  assign instr_valid   = (state == RUN) && in_range;
  assign bus.branch_en = instr_valid && is_br;
  assign bus.immediate = bus.branch_en ?
    {{2{bus.imem_rdata[5]}}, bus.imem_rdata[5:0]} : 8'h00;
  assign bus.zero      = zero_q;
  assign bus.imem_addr = bus.pc_in[AW-1:0];
  assign instr_out     = instr_valid ? bus.imem_rdata : {IW{1'b0}};

  // Range check wins over decode: an out-of-range PC never retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      zero_q      <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      instr_count <= 32'd0;
      taken_count <= 16'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (!in_range) begin
            state <= FAULT;
            fault <= 1'b1;
          end else begin
            instr_count <= instr_count + 32'd1;
            if (is_cmp)
              zero_q <= alu_zero;
            if (is_br && zero_q && taken_count != 16'hFFFF)
              taken_count <= taken_count + 16'd1;
            if (is_halt) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE:    ;
        FAULT:   ;
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed scoreboard bench for fetch_decode_ctrl.
// Expected outputs are queued on drive and checked mid-cycle.
module tb_fetch_decode_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_zero;
  logic [8:0]  instr_out;
  logic        instr_valid;
  logic        done;
  logic        fault;
  logic [31:0] instr_count;
  logic [15:0] taken_count;

  int compared   = 0;
  int mismatched = 0;

  fetch_decode_ctrl_if #(.IW(9), .AW(12)) bus ();

  fetch_decode_ctrl #(.IW(9), .AW(12), .DEPTH(4096)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .alu_zero    (alu_zero),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .done        (done),
    .fault       (fault),
    .instr_count (instr_count),
    .taken_count (taken_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        br;
    logic        zero;
    logic [7:0]  imm;
    logic [8:0]  iout;
    logic [11:0] addr;
    logic        done;
    logic        fault;
    logic [31:0] icnt;
    logic [15:0] tcnt;
  } exp_t;

  exp_t q[$];

  // reference model: 0 RUN, 1 DONE, 2 FAULT
  int          m_st   = 0;
  logic        m_zero = 1'b0;
  logic [31:0] m_icnt = 32'd0;
  logic [15:0] m_tcnt = 16'd0;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] x);
    compared++;
    assert (o === x) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  task automatic step(input logic r, input logic [31:0] pc,
                      input logic [8:0] ins, input logic az,
                      input bit en);
    exp_t e;
    exp_t g;
    logic v;
    logic br;
    reset          = r;
    bus.pc_in      = pc;
    bus.imem_rdata = ins;
    alu_zero       = az;
    v  = (m_st == 0) && (pc < 32'd4096);
    br = v && (ins[8:6] == 3'b111);
    e.valid = v;
    e.br    = br;
    e.zero  = m_zero;
    e.imm   = br ? {{2{ins[5]}}, ins[5:0]} : 8'h00;
    e.iout  = v ? ins : 9'd0;
    e.addr  = pc[11:0];
    e.done  = (m_st == 1);
    e.fault = (m_st == 2);
    e.icnt  = m_icnt;
    e.tcnt  = m_tcnt;
    q.push_back(e);
    @(negedge clk);
    g = q.pop_front();
    if (en) begin
      chk("instr_valid", 32'(instr_valid), 32'(g.valid));
      chk("branch_en", 32'(bus.branch_en), 32'(g.br));
      chk("zero", 32'(bus.zero), 32'(g.zero));
      chk("immediate", 32'(bus.immediate), 32'(g.imm));
      chk("instr_out", 32'(instr_out), 32'(g.iout));
      chk("imem_addr", 32'(bus.imem_addr), 32'(g.addr));
      chk("done", 32'(done), 32'(g.done));
      chk("fault", 32'(fault), 32'(g.fault));
      chk("instr_count", instr_count, g.icnt);
      chk("taken_count", 32'(taken_count), 32'(g.tcnt));
    end
    @(posedge clk);
    if (r) begin
      m_st = 0; m_zero = 1'b0; m_icnt = 32'd0; m_tcnt = 16'd0;
    end else if (m_st == 0) begin
      if (pc >= 32'd4096) m_st = 2;
      else begin
        m_icnt = m_icnt + 32'd1;
        if (ins[8:6] == 3'b111 && m_zero && m_tcnt != 16'hFFFF)
          m_tcnt = m_tcnt + 16'd1;
        if (ins[8:6] == 3'b101) m_zero = az;
        if (ins == 9'h1BF) m_st = 1;
      end
    end
    #1;
  endtask

  localparam logic [8:0] NOP  = 9'b000_010101;
  localparam logic [8:0] CMP  = 9'b101_000000;
  localparam logic [8:0] BRM2 = 9'b111_111110;
  localparam logic [8:0] BRP5 = 9'b111_000101;
  localparam logic [8:0] HALT = 9'b110_111111;

  initial begin
    reset = 1'b1;
    alu_zero = 1'b0;
    bus.pc_in = 32'd0;
    bus.imem_rdata = 9'd0;
    @(posedge clk);
    #1;
    step(1, 0, NOP, 0, 1);
    step(1, 0, NOP, 0, 1);
    chk("rst_icount", instr_count, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 5; i++)
      step(0, 32'(i), NOP ^ 9'(i), 0, 1);
    chk("straight_icount", instr_count, 32'd5);
    step(0, 5, CMP, 1, 1);
    step(0, 6, BRM2, 0, 1);
    chk("taken_one", 32'(taken_count), 32'd1);
    step(0, 7, HALT, 0, 1);
    chk("halt_icount", instr_count, 32'd8);
    chk("halt_done", 32'(done), 32'd1);
    for (int i = 8; i < 18; i++)
      step(0, 32'(i), BRP5, 1, 1);
    chk("done_frozen_icount", instr_count, 32'd8);
    chk("done_frozen_taken", 32'(taken_count), 32'd1);
    // reset from DONE, then flag-clear branch
    step(1, 18, NOP, 0, 1);
    chk("rst_done_icount", instr_count, 32'd0);
    chk("rst_done_zero", 32'(bus.zero), 32'd0);
    step(0, 0, CMP, 1, 1);
    step(0, 1, CMP, 0, 1);
    step(0, 2, BRP5, 1, 1);
    chk("clr_taken", 32'(taken_count), 32'd0);
    chk("clr_icount", instr_count, 32'd3);
    // fault at pc == DEPTH
    step(0, 4095, NOP, 0, 1);
    step(0, 4096, BRP5, 0, 1);
    step(0, 4097, NOP, 0, 1);
    chk("fault_set", 32'(fault), 32'd1);
    chk("fault_done", 32'(done), 32'd0);
    chk("fault_icount", instr_count, 32'd4);
    // reset wins over halt / fault in the same cycle
    step(1, 3, HALT, 0, 1);
    step(0, 0, NOP, 0, 1);
    chk("rst_halt_run", 32'(done), 32'd0);
    step(1, 4096, NOP, 0, 1);
    step(0, 1, NOP, 0, 1);
    chk("rst_fault_run", 32'(fault), 32'd0);
    // saturation
    step(1, 0, NOP, 0, 1);
    step(0, 0, CMP, 1, 1);
    for (int i = 0; i < 65537; i++)
      step(0, 32'((i + 1) % 4096), BRM2, 0, (i < 4 || i > 65530));
    chk("taken_sat", 32'(taken_count), 32'hFFFF);
    chk("sat_icount", instr_count, 32'd65538);
    step(0, 4095, HALT, 0, 1);
    step(0, 4096, NOP, 0, 1);
    chk("halt_last_done", 32'(done), 32'd1);
    chk("halt_last_fault", 32'(fault), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_decode_ctrl.md
# fetch_decode_ctrl

Front-end controller on the consumer side of the program counter. It takes the current PC, addresses instruction memory, and decodes the returned instruction. It drives the PC's branch controls (`branch_en`, `zero`, `immediate`) and holds the zero flag set by compare instructions. A small run/done/fault state machine gates instruction retirement and keeps retired-instruction and taken-branch counters for bench and debug use.

## Interface
Parameters:
- `IW`, 9, instruction width
- `AW`, 12, instruction-memory address width
- `DEPTH`, 4096, number of valid instruction words; `DEPTH` <= 2^AW

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset; sampled on the rising edge of `clk`
- `pc_in`  in  32  current PC from the program counter
- `imem_addr`  out  AW  instruction-memory address; equals `pc_in[AW-1:0]`
- `imem_rdata`  in  IW  instruction word; asynchronous read, valid in the same cycle as `imem_addr`
- `alu_zero`  in  1  ALU zero result, sampled when a compare retires
- `instr_out`  out  IW  decoded instruction passed to the datapath
- `instr_valid`  out  1  instruction retires this cycle; datapath write-enables are gated by it
- `branch_en`  out  1  to the PC: the current instruction is a branch
- `zero`  out  1  to the PC: registered zero flag
- `immediate`  out  8  to the PC: sign-extended branch offset
- `done`  out  1  HALT has retired
- `fault`  out  1  the PC left instruction memory
- `instr_count`  out  32  number of retired instructions
- `taken_count`  out  16  number of taken branches, saturating

## Operation
Decoding uses the opcode field `op = imem_rdata[8:6]`:
- `3'b111`: branch. `immediate = {{2{imem_rdata[5]}}, imem_rdata[5:0]}`.
- `3'b101`: compare. Sets `zero_q <= alu_zero` on retire.
- `3'b110` with `[5:0] == 6'h3F`: HALT.
- All other encodings: ordinary instructions, passed through unchanged.

The state machine has three states: RUN, DONE and FAULT. Reset enters RUN.
- RUN → FAULT when `pc_in >= DEPTH` (32-bit unsigned compare). This check takes priority over decode. The faulting cycle does not retire.
- RUN → DONE when HALT is decoded with `pc_in < DEPTH`. The HALT instruction itself retires.
- DONE and FAULT are absorbing. Only `reset` leaves them.

Combinational outputs, all zero unless otherwise stated:
- `instr_valid` = RUN && `pc_in < DEPTH`.
- `branch_en` = `instr_valid` && `op == 3'b111`.
- `immediate` = the decoded offset when `branch_en`, else `8'h00`.
- `zero` = `zero_q` at all times.
- `instr_out` = `imem_rdata` when `instr_valid`, else `{IW{1'b0}}`.

Registered outputs:
- `done` and `fault` are registered state decodes.
- `instr_count` increments by 1 on every `instr_valid` cycle. It wraps modulo 2^32.
- `taken_count` increments on `branch_en && zero_q` and saturates at `16'hFFFF`.
- The zero flag is not cleared by a branch. Only compares and `reset` change it.

## Timing
Reset values: state = RUN, `zero_q` = 0, `done` = 0, `fault` = 0, `instr_count` = 0, `taken_count` = 0.

Latency:
- Decode is zero-latency: branch controls reach the PC in the same cycle that `pc_in` is presented.
- A compare in cycle N updates `zero_q` at the edge ending cycle N. A branch in cycle N+1 sees the new flag.
- HALT retires in cycle N. `done` is high from cycle N+1. `instr_valid` is low from cycle N+1.
- On a fault in cycle N, `fault` is high from cycle N+1.

Boundary conditions:
- Reset asserted mid-run has priority over every transition and counter update. All registers take their reset values at that edge.
- Reset in the same cycle as HALT or a fault: reset wins and the block stays in RUN.
- HALT at `pc_in == DEPTH-1` retires normally and leads to DONE.
- `pc_in == DEPTH` leads to FAULT.
- In DONE and FAULT the PC keeps advancing. `branch_en`, `instr_valid` and `immediate` stay 0, and the counters and `zero_q` are frozen.
- `imem_addr` is always driven from `pc_in`, even in DONE and FAULT.

## Test plan
- **Reset then straight-line code.** Apply reset for 2 cycles, then run 5 ordinary instructions. Required: `instr_count` = 5, `branch_en` = 0 throughout, `done` = 0, `fault` = 0.
- **Compare then branch.** Compare with `alu_zero` = 1, followed by a branch with offset `6'h3E` (−2). Required: `zero` = 1, `immediate` = `8'hFE`, `branch_en` = 1, `taken_count` = 1.
- **Branch with the flag clear.** Compare with `alu_zero` = 0, then a branch. Required: `branch_en` = 1, `zero` = 0, `taken_count` unchanged, `instr_count` still increments.
- **HALT at PC 7.** Required: `instr_count` = 8 at the next edge, `done` = 1, and `instr_valid` = 0 and `branch_en` = 0 for the next 10 cycles while `pc_in` keeps advancing. Counters stay frozen.
- **Fault.** Drive `pc_in` = 4096 with `DEPTH` = 4096. Required: that cycle does not retire, `fault` = 1 from the next cycle, `done` = 0.
- **Reset in DONE, plus saturation.** Assert reset while in DONE. Required: RUN, all counters 0, `zero` = 0. Then force 65,537 taken branches. Required: `taken_count` = `16'hFFFF`.
